// File: rtl/led_ctrl_pkg.sv
// Shared constants for the memory-mapped LED controller: register indices
// and the reset prescaler period.
package led_ctrl_pkg;

    localparam logic [1:0]  LED_REG_DATA   = 2'd0;
    localparam logic [1:0]  LED_REG_MASK   = 2'd1;
    localparam logic [1:0]  LED_REG_PERIOD = 2'd2;
    localparam logic [1:0]  LED_REG_STATUS = 2'd3;

    // 2 Hz blink at 50 MHz: half-period is DEFAULT_PERIOD + 1 cycles.
    localparam logic [23:0] DEFAULT_PERIOD = 24'd12_499_999;

endpackage

// File: rtl/led_ctrl_if.sv
// CPU data-bus port of the LED controller: request, write data and the
// registered one-cycle acknowledge with read data.
interface led_ctrl_if;

    logic        bus_en;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_en, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_en, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/led_blink_timer.sv
// Blink prescaler: counts up to the programmed period, then wraps and flips
// the blink phase. A PERIOD write restarts the count without touching phase.
module led_blink_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] period_i,
    input  logic             clr_i,
    output logic             phase_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // Next count/phase; the restart from a PERIOD write overrides a terminal count.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == period_i) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Prescaler state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/led_ctrl.sv
// LED controller top: bus register file (DATA, BLINK_MASK, PERIOD, STATUS),
// one-cycle registered read/ack path and blink masking of the LED pattern.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int               DATA_W         = 8,
    parameter int               CNT_W          = 24,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = led_ctrl_pkg::DEFAULT_PERIOD
) (
    input  logic              clk,
    input  logic              rst_n,
    led_ctrl_if.slave         bus,
    output logic [DATA_W-1:0] led_data
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ack_q, ack_d;

    logic              wr_s, rd_s, period_wr_s;
    logic              phase_s;
    logic [CNT_W-1:0]  cnt_s;
    logic [31:0]       status_s, rd_word_s;
    logic              unused_bits_s;

    assign wr_s        = bus.bus_en & bus.bus_we;
    assign rd_s        = bus.bus_en & ~bus.bus_we;
    assign period_wr_s = wr_s & (bus.bus_addr == LED_REG_PERIOD);

    // STATUS only has room for the low count bits above the phase byte.
    assign unused_bits_s = ^{bus.bus_wdata[31:CNT_W], cnt_s[CNT_W-1:CNT_W-6]};

    led_blink_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .period_i (period_q),
        .clr_i    (period_wr_s),
        .phase_o  (phase_s),
        .cnt_o    (cnt_s)
    );

    // Register writes, read mux and output pattern.
    always_comb begin
        data_d    = data_q;
        mask_d    = mask_q;
        period_d  = period_q;
        status_s  = 32'd0;
        rd_word_s = 32'd0;

        status_s[0]         = phase_s;
        status_s[CNT_W+1:8] = cnt_s[CNT_W-7:0];

        if (wr_s) begin
            case (bus.bus_addr)
                LED_REG_DATA:   data_d   = bus.bus_wdata[DATA_W-1:0];
                LED_REG_MASK:   mask_d   = bus.bus_wdata[DATA_W-1:0];
                LED_REG_PERIOD: period_d = bus.bus_wdata[CNT_W-1:0];
                default:        data_d   = data_q;
            endcase
        end else begin
            data_d = data_q;
        end

        case (bus.bus_addr)
            LED_REG_DATA:   rd_word_s = 32'(data_q);
            LED_REG_MASK:   rd_word_s = 32'(mask_q);
            LED_REG_PERIOD: rd_word_s = 32'(period_q);
            LED_REG_STATUS: rd_word_s = status_s;
            default:        rd_word_s = 32'd0;
        endcase

        if (rd_s) begin
            rdata_d = rd_word_s;
        end else begin
            rdata_d = 32'd0;
        end

        ack_d = bus.bus_en;
        led_d = data_q & ~(mask_q & {DATA_W{phase_s}});
    end

    // Register file and registered bus/LED outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            mask_q   <= '0;
            period_q <= DEFAULT_PERIOD;
            led_q    <= '0;
            rdata_q  <= 32'd0;
            ack_q    <= 1'b0;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            led_q    <= led_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
        end
    end

    // led_data feeds the led stage's data_in.
    assign led_data      = led_q;
    assign bus.bus_rdata = rdata_q;
    assign bus.bus_ack   = ack_q;

endmodule

// File: doc/led_ctrl.md
# led_ctrl

Memory-mapped LED controller between the CPU data bus and the `led` output stage. It latches CPU writes into an 8-bit LED data register and applies an optional per-bit blink pattern driven by a programmable prescaler. The resulting 8-bit pattern drives the `led` stage's `data_in`. Registers are read back over the same bus with a fixed one-cycle acknowledge.

## Interface

Parameters:
- `DATA_W`, 8: LED width; must match the `led` stage.
- `CNT_W`, 24: prescaler counter width.
- `DEFAULT_PERIOD`, 24'd12_499_999: reset value of PERIOD; gives 2 Hz blink at 50 MHz.

Ports:
- `clk`, input, 1: single clock; all state is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `bus_en`, input, 1: access request, sampled every cycle.
- `bus_we`, input, 1: 1 means write, 0 means read; qualified by `bus_en`.
- `bus_addr`, input, 2: register select (word index).
- `bus_wdata`, input, 32: write data.
- `bus_rdata`, output, 32: registered read data; valid when `bus_ack` is high.
- `bus_ack`, output, 1: one-cycle acknowledge for each accepted access.
- `led_data`, output, DATA_W: pattern that feeds the `led` stage's `data_in`.

## Operation

Register map (index `bus_addr`):
- 0 DATA (`DATA_W` bits): static LED pattern.
- 1 BLINK_MASK (`DATA_W` bits): bits that blink.
- 2 PERIOD (`CNT_W` bits): prescaler terminal count.
- 3 STATUS (read-only): bit0 is `phase`, bits[CNT_W+1:8] hold `cnt` snapshot; other bits 0. Writes to STATUS are ignored but still acknowledged.

Write and read rules:
- A write is accepted when `bus_en && bus_we` at an edge. Data is taken from `bus_wdata[W-1:0]`; upper bits are ignored.
- A read is accepted when `bus_en && !bus_we`. `bus_rdata` is zero-extended register content.
- Output: `led_data = DATA & ~(BLINK_MASK & {DATA_W{phase}})`, registered.

Prescaler (P = PERIOD):
- `cnt` increments each cycle. When `cnt == P`, `cnt` returns to 0 and `phase` toggles. The phase half-period is therefore P+1 cycles.
- P = 0 toggles `phase` every cycle.
- Writing PERIOD clears `cnt` to 0 and leaves `phase` unchanged. If the write lands on the same edge as a terminal count, the write wins and there is no toggle that cycle.
- If PERIOD is written below the current `cnt`, the clear above guarantees no long wrap through 2^CNT_W.

Reset values: DATA=0, BLINK_MASK=0, PERIOD=DEFAULT_PERIOD, `cnt`=0, `phase`=0, `led_data`=0, `bus_ack`=0, `bus_rdata`=0. Reset mid-access drops the pending ack; no ack is produced for an access interrupted by reset.

## Timing

- Write at edge N: the register updates at N, and `led_data` reflects it after edge N+1 (2-cycle bus-to-pin latency).
- Read at edge N: `bus_rdata` and `bus_ack` are valid from edge N+1 for exactly one cycle. The value is the register content before any write accepted at edge N.
- Back-to-back: `bus_en` held high for k cycles yields k accesses and k consecutive ack cycles, each lagging by one cycle. There are no wait states and no backpressure.
- `bus_rdata` returns 0 in cycles with no ack.
- The `phase` toggle at edge N is visible on `led_data` after edge N+1.

## Structure

- Package `led_ctrl_pkg`: register index constants `LED_REG_DATA`=0, `LED_REG_MASK`=1, `LED_REG_PERIOD`=2, `LED_REG_STATUS`=3, plus `DEFAULT_PERIOD`.
- Sub-module `led_blink_timer`: contains `cnt`, `phase`, the PERIOD-write clear input and the terminal-count logic. Its outputs are `phase` and `cnt`.
- Top-level `led_ctrl`: address decode, the three registers, read mux, ack flop and output masking. It instantiates `led_blink_timer` and connects `led_data` to `led.data_in`.

## Test plan

- Reset: hold `rst_n`=0 mid-cycle, asynchronously. Expect all outputs 0 immediately. A STATUS read after release returns 0, and a PERIOD read returns DEFAULT_PERIOD.
- Static write: write DATA=0xA5 at edge N. Expect `led_data`=0xA5 after edge N+1, and `bus_ack` high only in cycle N+1.
- Blink: PERIOD=3, DATA=0xFF, MASK=0x0F. Expect `led_data` to alternate 0xFF and 0xF0, each held for exactly 4 cycles.
- Collision: write PERIOD=5 on the same edge as a terminal count. Expect no phase toggle at that edge, `cnt`=0, and the next toggle 6 cycles later.
- Back-to-back reads of indices 0,1,2,3 with `bus_en` held high for 4 cycles. Expect 4 consecutive ack cycles with data in order and zero-extended. A write to STATUS is acknowledged and changes nothing.
